// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles the core load/store, debug/DMA and data-memory signals of dmem_arbiter.
// Latency: core path is combinational; debug response (ack/err/rdata) arrives one cycle after dbg_gnt.
// Backpressure: core is frozen by core_stall; debug holds its request until dbg_gnt.
// Ports: core_* = core load/store path, dbg_* = debug/DMA requester, mem_* = single-port data memory.
// Modports: slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            core_req;
   logic            core_we;
   logic [XLEN-1:0] core_addr;
   logic [XLEN-1:0] core_wdata;
   logic [XLEN-1:0] core_rdata;
   logic            core_gnt;
   logic            core_stall;
   logic            core_fault;

   logic            dbg_req;
   logic            dbg_we;
   logic            dbg_lock;
   logic [XLEN-1:0] dbg_addr;
   logic [XLEN-1:0] dbg_wdata;
   logic            dbg_gnt;
   logic            dbg_ack;
   logic            dbg_err;
   logic [XLEN-1:0] dbg_rdata;

   logic [XLEN-1:0] mem_address;
   logic [XLEN-1:0] mem_write_data;
   logic            mem_write_enable;
   logic [XLEN-1:0] mem_read_data;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      input  mem_read_data,
      output core_rdata, core_gnt, core_stall, core_fault,
      output dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
      output mem_address, mem_write_data, mem_write_enable
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
      output mem_read_data,
      input  core_rdata, core_gnt, core_stall, core_fault,
      input  dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
      input  mem_address, mem_write_data, mem_write_enable
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port data memory between the core load/store path and a debug/DMA port.
// Latency: core served combinationally in its own cycle; debug ack/err/rdata registered, one cycle after dbg_gnt.
// Backpressure: losing core sees core_stall; debug waits for dbg_gnt; locked bursts capped at MAX_BURST grants.
// Ports: clock, reset (async, active-high), bus (dmem_arbiter_if.slave: core_*, dbg_*, mem_*).
module dmem_arbiter #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 128,
   parameter int MAX_BURST = 4
) (
   input  logic           clock,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   localparam int              CW       = $clog2(MAX_BURST + 1);
   localparam logic [XLEN-1:0] LIMIT    = XLEN'(DEPTH * 4);
   localparam bit              BURST_EN = (MAX_BURST > 1);

   typedef enum logic {ARB, BURST} state_t;

   state_t          state;
   logic            prio;        // 1: debug wins the next contended cycle
   logic [CW-1:0]   burst_cnt;
   logic            ack_r;
   logic            err_r;
   logic [XLEN-1:0] rdata_r;

   logic core_in_range;
   logic dbg_in_range;
   logic burst_hold;
   logic eff_prio;
   logic core_sel;
   logic dbg_sel;

   assign core_in_range = (bus.core_addr < LIMIT);
   assign dbg_in_range  = (bus.dbg_addr < LIMIT);

   // A locked burst keeps the memory only while under the cap; once it
   // breaks, the core gets first pick of the contended cycle.
   assign burst_hold = (state == BURST) && bus.dbg_req && bus.dbg_lock &&
                       (burst_cnt < CW'(MAX_BURST));
   assign eff_prio   = (state == BURST) ? 1'b0 : prio;

   always_comb begin
      core_sel = 1'b0;
      dbg_sel  = 1'b0;
      if (!reset) begin
         if (burst_hold)
            dbg_sel = 1'b1;
         else if (bus.core_req && bus.dbg_req) begin
            if (eff_prio) dbg_sel  = 1'b1;
            else          core_sel = 1'b1;
         end
         else if (bus.core_req)
            core_sel = 1'b1;
         else if (bus.dbg_req)
            dbg_sel = 1'b1;
      end
   end

   assign bus.core_gnt   = core_sel;
   assign bus.dbg_gnt    = dbg_sel;
   assign bus.core_stall = bus.core_req & ~core_sel;
   assign bus.core_fault = core_sel & ~core_in_range;
   assign bus.core_rdata = (core_sel && core_in_range) ? bus.mem_read_data : '0;

   assign bus.mem_address    = core_sel ? bus.core_addr  : (dbg_sel ? bus.dbg_addr  : '0);
   assign bus.mem_write_data = core_sel ? bus.core_wdata : (dbg_sel ? bus.dbg_wdata : '0);
   // Out-of-range writes are dropped here rather than aliased into memory.
   assign bus.mem_write_enable = (core_sel & bus.core_we & core_in_range) |
                                 (dbg_sel  & bus.dbg_we  & dbg_in_range);

   assign bus.dbg_ack   = ack_r;
   assign bus.dbg_err   = err_r;
   assign bus.dbg_rdata = rdata_r;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ARB;
         prio      <= 1'b0;
         burst_cnt <= '0;
         ack_r     <= 1'b0;
         err_r     <= 1'b0;
         rdata_r   <= '0;
      end
      else begin
         ack_r <= dbg_sel;
         if (dbg_sel) begin
            err_r   <= ~dbg_in_range;
            rdata_r <= (!bus.dbg_we && dbg_in_range) ? bus.mem_read_data : '0;
         end

         if (burst_hold) begin
            burst_cnt <= burst_cnt + CW'(1);
         end
         else begin
            // Whoever was just served yields the next contended cycle.
            if (core_sel)
               prio <= 1'b1;
            else if (dbg_sel)
               prio <= 1'b0;

            if ((state == ARB) && dbg_sel && bus.dbg_lock && BURST_EN) begin
               state     <= BURST;
               burst_cnt <= CW'(1);
            end
            else begin
               state     <= ARB;
               burst_cnt <= '0;
            end
         end
      end
   end
endmodule
